// File: rtl/mig_u_fetch_if.sv
// Mig-U fetch stage bus: reset/redirect control, instruction memory port and
// the instruction handshake toward decode. The fetch stage uses the master view.
interface mig_u_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned PW = ADDR_WIDTH - 2;

    logic [PW-1:0] rst_addr;
    logic          redirect_valid;
    logic [PW-1:0] redirect_addr;

    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [PW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          imem_rsp_err;

    logic          insn_valid;
    logic          insn_ready;
    logic [31:0]   insn;
    logic [PW-1:0] insn_pc;
    logic          insn_fault;

    modport master (
        input  rst_addr, redirect_valid, redirect_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  insn_ready,
        output imem_req_valid, imem_req_addr,
        output insn_valid, insn, insn_pc, insn_fault
    );

    modport slave (
        output rst_addr, redirect_valid, redirect_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output insn_ready,
        input  imem_req_valid, imem_req_addr,
        input  insn_valid, insn, insn_pc, insn_fault
    );
endinterface

// File: rtl/mig_u_fetch.sv
// Mig-U instruction fetch stage: credit-limited in-order requests, a small
// instruction FIFO toward decode, redirect flush with stale-response dropping,
// and halt-on-fault until the next redirect.
module mig_u_fetch #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic          clk,
    input  logic          rst,
    mig_u_fetch_if.master fetch_bus
);
    localparam int unsigned PW   = ADDR_WIDTH - 2;
    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e          state_q;
    logic [PW-1:0]   pc_q, pc_d;
    logic [PW-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] out_q, out_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]          buf_data_q [BUF_DEPTH];
    logic [PW-1:0]        buf_pc_q   [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] buf_err_q;

    logic insn_valid;
    logic pop;
    logic credit_ok;
    logic req_fire;
    logic push;

    // A same-cycle dequeue frees its credit immediately so 1-cycle memory sustains 1 IPC.
    assign insn_valid = !rst && (cnt_q != '0);
    assign pop        = insn_valid && fetch_bus.insn_ready;
    assign credit_ok  = (32'(out_q) + 32'(cnt_q)) < (BUF_DEPTH + 32'(pop));
    assign req_fire   = fetch_bus.imem_req_valid && fetch_bus.imem_req_ready;
    // Only responses of the current path land in the buffer; a redirect flushes this cycle's.
    assign push       = fetch_bus.imem_rsp_valid && (drop_q == '0) && !fetch_bus.redirect_valid;

    assign fetch_bus.imem_req_valid = !rst && (state_q == StRun) && !fetch_bus.redirect_valid
                                      && credit_ok;
    assign fetch_bus.imem_req_addr  = rst ? '0 : pc_q;
    assign fetch_bus.insn_valid     = insn_valid;
    assign fetch_bus.insn           = insn_valid ? buf_data_q[rd_ptr_q] : '0;
    assign fetch_bus.insn_pc        = insn_valid ? buf_pc_q[rd_ptr_q] : '0;
    assign fetch_bus.insn_fault     = insn_valid && buf_err_q[rd_ptr_q];

    // Next-state for PCs, credit counters and FIFO pointers.
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q + CntW'(req_fire) - CntW'(fetch_bus.imem_rsp_valid);
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fetch_bus.redirect_valid) begin
            pc_d     = fetch_bus.redirect_addr;
            rsp_pc_d = fetch_bus.redirect_addr;
            // Everything still in flight belongs to the abandoned path.
            drop_d   = out_d;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PW'(1);
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (fetch_bus.imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CntW'(1);
            end
            cnt_d = cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    // Control state, including the RUN/HALT machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            pc_q     <= fetch_bus.rst_addr;
            rsp_pc_q <= fetch_bus.rst_addr;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            unique case (state_q)
                StRun: begin
                    if (!fetch_bus.redirect_valid && push && fetch_bus.imem_rsp_err) begin
                        state_q <= StHalt;
                    end
                end
                StHalt: begin
                    if (fetch_bus.redirect_valid) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // Buffer storage; faulting entries carry a zero instruction word.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= fetch_bus.imem_rsp_err ? '0 : fetch_bus.imem_rsp_data;
            buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
            buf_err_q[wr_ptr_q]  <= fetch_bus.imem_rsp_err;
        end
    end

    // A response may only answer an accepted request.
    a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
        fetch_bus.imem_rsp_valid |-> (out_q != '0));

    // Credits must keep the buffer from overflowing.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !pop) |-> (cnt_q != CntW'(BUF_DEPTH)));
endmodule

// File: tb/tb_mig_u_fetch.sv
// Self-checking bench for mig_u_fetch: an in-order memory model plus an
// architectural reference of the expected instruction stream.
module tb_mig_u_fetch;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned BUF_DEPTH  = 2;
    localparam int unsigned PW         = ADDR_WIDTH - 2;

    typedef struct {
        logic [PW-1:0] addr;
        int            epoch;
        int            due;
    } mreq_t;

    logic clk = 1'b0;
    logic rst;

    mig_u_fetch_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus_if ();

    mig_u_fetch #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_bus(bus_if.master)
    );

    always #5 clk = ~clk;

    int            n_checks;
    int            n_errors;
    int            cyc;
    mreq_t         mq[$];
    int            epoch;
    int            last_due;
    int            mem_lat;
    int            err_mode;
    logic [PW-1:0] exp_pc;
    logic [PW-1:0] exp_req_pc;
    logic          halted;
    int            delivered;
    int            accepted;
    logic          first_set;
    logic [PW-1:0] first_pc;
    logic          saw_fault;
    logic [PW-1:0] fault_pc;
    logic          saw_wrap;
    logic          s_req_valid;
    logic          s_insn_valid;
    logic          hold_insn;
    logic [62:0]   hold_val;
    logic          hold_req;
    logic [PW-1:0] hold_addr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [PW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic is_err(input logic [PW-1:0] a);
        return ((err_mode == 1) && (32'(a) == 32'h11)) || ((err_mode == 2) && (a[4:0] == 5'h13));
    endfunction

    // Judge one cycle from outputs sampled mid-cycle, then advance the reference.
    task automatic evaluate(input logic rsp_live);
        logic          rv, iv, redir, fault_now;
        logic [PW-1:0] pc;
        int            lat, due;
        rv    = bus_if.imem_req_valid;
        iv    = bus_if.insn_valid;
        redir = bus_if.redirect_valid;
        pc    = bus_if.insn_pc;
        s_req_valid  = rv;
        s_insn_valid = iv;
        if (rst) begin
            check_val("rst_ctl", {61'd0, rv, iv, bus_if.insn_fault}, 64'd0);
            check_val("rst_insn", {bus_if.insn, pc}, 64'd0);
            check_val("rst_req_addr", 64'(bus_if.imem_req_addr), 64'd0);
            mq.delete();
            last_due   = cyc;
            epoch++;
            exp_pc     = bus_if.rst_addr;
            exp_req_pc = bus_if.rst_addr;
            halted     = 1'b0;
            hold_insn  = 1'b0;
            hold_req   = 1'b0;
        end else begin
            if (hold_insn) begin
                check_val("hold_valid", 64'(iv), 64'd1);
                check_val("hold_insn", 64'({bus_if.insn, pc, bus_if.insn_fault}), 64'(hold_val));
            end
            if (hold_req && !redir) begin
                check_val("hold_req", 64'({rv, bus_if.imem_req_addr}), 64'({1'b1, hold_addr}));
            end
            if (redir) check_val("redir_noreq", 64'(rv), 64'd0);
            if (halted) check_val("halt_noreq", 64'(rv), 64'd0);
            if (iv && bus_if.insn_ready) begin
                check_val("insn_pc", 64'(pc), 64'(exp_pc));
                check_val("insn_fault", 64'(bus_if.insn_fault), 64'(is_err(exp_pc)));
                check_val("insn_data", 64'(bus_if.insn),
                          is_err(exp_pc) ? 64'd0 : 64'(mem_data(exp_pc)));
                if (!first_set) begin
                    first_set = 1'b1;
                    first_pc  = pc;
                end
                if (bus_if.insn_fault) begin
                    saw_fault = 1'b1;
                    fault_pc  = pc;
                end
                if (pc == '0) saw_wrap = 1'b1;
                exp_pc = exp_pc + PW'(1);
                delivered++;
            end
            if (rv && bus_if.imem_req_ready) begin
                check_val("req_addr", 64'(bus_if.imem_req_addr), 64'(exp_req_pc));
                lat = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                mq.push_back('{addr: exp_req_pc, epoch: epoch, due: due});
                last_due   = due;
                exp_req_pc = exp_req_pc + PW'(1);
                accepted++;
            end
            fault_now = bus_if.imem_rsp_valid && rsp_live && bus_if.imem_rsp_err && !redir;
            hold_insn = iv && !bus_if.insn_ready && !redir;
            hold_val  = {bus_if.insn, pc, bus_if.insn_fault};
            hold_req  = rv && !bus_if.imem_req_ready && !fault_now;
            hold_addr = bus_if.imem_req_addr;
            if (fault_now) halted = 1'b1;
            if (redir) begin
                epoch++;
                exp_pc     = bus_if.redirect_addr;
                exp_req_pc = bus_if.redirect_addr;
                halted     = 1'b0;
            end
        end
    endtask

    // One clock: memory drives its response, outputs are judged at negedge.
    task automatic cycle();
        mreq_t cur;
        logic  rsp_live;
        rsp_live = 1'b0;
        if (!rst && (mq.size() > 0) && (mq[0].due <= cyc)) begin
            cur = mq.pop_front();
            bus_if.imem_rsp_valid = 1'b1;
            bus_if.imem_rsp_err   = is_err(cur.addr);
            bus_if.imem_rsp_data  = bus_if.imem_rsp_err ? $urandom : mem_data(cur.addr);
            rsp_live = (cur.epoch == epoch);
        end else begin
            bus_if.imem_rsp_valid = 1'b0;
            bus_if.imem_rsp_err   = 1'b0;
            bus_if.imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        evaluate(rsp_live);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input logic [PW-1:0] a);
        rst                   = 1'b1;
        bus_if.rst_addr       = a;
        bus_if.redirect_valid = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        bus_if.insn_ready     = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic redirect_to(input logic [PW-1:0] a);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_addr  = a;
        cycle();
        bus_if.redirect_valid = 1'b0;
        first_set = 1'b0;
    endtask

    initial begin
        int nv, a0, d0;
        n_checks = 0; n_errors = 0; cyc = 0; epoch = 0; last_due = 0;
        delivered = 0; accepted = 0; halted = 1'b0;
        hold_insn = 1'b0; hold_req = 1'b0; hold_val = '0; hold_addr = '0;
        first_set = 1'b0; first_pc = '0; saw_fault = 1'b0; fault_pc = '0; saw_wrap = 1'b0;
        exp_pc = '0; exp_req_pc = '0;
        rst = 1'b1;
        bus_if.rst_addr = '0; bus_if.redirect_valid = 1'b0; bus_if.redirect_addr = '0;
        bus_if.imem_req_ready = 1'b1; bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data = '0; bus_if.imem_rsp_err = 1'b0; bus_if.insn_ready = 1'b1;

        // Startup latency and sustained throughput with 1-cycle memory.
        err_mode = 0; mem_lat = 1;
        do_reset(PW'(32'h400));
        first_set = 1'b0;
        cycle(); check_val("first_valid_c0", 64'(s_insn_valid), 64'd0);
        cycle(); check_val("first_valid_c1", 64'(s_insn_valid), 64'd0);
        cycle(); check_val("first_valid_c2", 64'(s_insn_valid), 64'd1);
        check_val("first_pc", 64'(first_pc), 64'h400);
        nv = 0; a0 = accepted;
        repeat (20) begin
            cycle();
            nv += int'(s_insn_valid);
        end
        check_val("thruput", 64'(nv), 64'd20);
        check_val("req_rate", 64'(accepted - a0), 64'd20);

        // Core stall: credits cap requests, then in-order release.
        do_reset(PW'(32'h40));
        bus_if.insn_ready = 1'b0;
        a0 = accepted;
        repeat (10) cycle();
        check_val("stall_accepts", 64'(accepted - a0), 64'(BUF_DEPTH));
        check_val("stall_reqv", 64'(s_req_valid), 64'd0);
        check_val("stall_valid", 64'(s_insn_valid), 64'd1);
        bus_if.insn_ready = 1'b1;
        d0 = delivered;
        repeat (12) cycle();
        check_val("stall_progress", 64'((delivered - d0) >= 10), 64'd1);

        // Redirect with stale responses in flight.
        mem_lat = 3;
        do_reset(PW'(32'h10));
        repeat (8) cycle();
        redirect_to(PW'(32'h80));
        d0 = delivered;
        repeat (15) cycle();
        check_val("redir_first_pc", 64'({first_set, first_pc}), 64'({1'b1, PW'(32'h80)}));
        check_val("redir_progress", 64'((delivered - d0) >= 3), 64'd1);

        // Access fault halts fetch until a redirect.
        err_mode = 1; mem_lat = 1;
        do_reset(PW'(32'h0E));
        saw_fault = 1'b0;
        repeat (12) cycle();
        check_val("fault_seen", 64'({saw_fault, fault_pc}), 64'({1'b1, PW'(32'h11)}));
        check_val("halt_idle", 64'({s_req_valid, s_insn_valid}), 64'd0);
        redirect_to(PW'(32'h20));
        repeat (10) cycle();
        check_val("resume_pc", 64'({first_set, first_pc}), 64'({1'b1, PW'(32'h20)}));

        // PC wrap from all-ones to zero.
        err_mode = 0;
        do_reset({PW{1'b1}} - PW'(2));
        saw_wrap = 1'b0;
        repeat (12) cycle();
        check_val("pc_wrap", 64'(saw_wrap), 64'd1);

        // Reset mid-stream with work in flight and buffered.
        mem_lat = 3;
        do_reset(PW'(32'h100));
        bus_if.insn_ready = 1'b0;
        repeat (5) cycle();
        do_reset(PW'(32'h200));
        first_set = 1'b0;
        cycle(); check_val("rst_clean_c0", 64'(s_insn_valid), 64'd0);
        cycle(); check_val("rst_clean_c1", 64'(s_insn_valid), 64'd0);
        repeat (15) cycle();
        check_val("rst_first_pc", 64'({first_set, first_pc}), 64'({1'b1, PW'(32'h200)}));

        // Randomized traffic: backpressure, latency, redirects, faults, resets.
        err_mode = 2; mem_lat = 0;
        do_reset(PW'($urandom));
        d0 = delivered;
        repeat (3000) begin
            bus_if.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus_if.insn_ready     = ($urandom_range(0, 3) != 0);
            rst                   = ($urandom_range(0, 299) == 0);
            bus_if.rst_addr       = PW'($urandom);
            bus_if.redirect_valid = ($urandom_range(0, 19) == 0);
            bus_if.redirect_addr  = PW'($urandom);
            cycle();
        end
        check_val("rand_progress", 64'((delivered - d0) > 300), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
